grf_dump_reader: RTL

Sequential read-side companion to the CPU general register file: on a start pulse it walks a range of register indices through a spare GRF read port, captures each value, and streams (index, value) pairs out over a valid/ready handshake to a debug/trace sink. While dumping it asserts a stall request so the datapath freezes and the snapshot stays consistent. It sits beside the GRF in the single-cycle CPU top, with its read port muxed onto GRF port 2 when `stall_req` is high.

---
 rtl/grf_dump_reader.sv | 111 +++++++++++
 1 files changed

// File: rtl/grf_dump_reader.sv
// Walks a range of GRF indices through a spare read port and streams
// (index, value) beats to a debug sink while stalling the CPU datapath.
module grf_dump_reader #(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        stall_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_reg,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_HOLD, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  rd_addr_d;
  logic        out_valid_d;
  logic [4:0]  out_reg_d;
  logic [31:0] out_data_d;
  logic        at_last;

  assign at_last = (idx_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_addr_d   = rd_addr;
    out_valid_d = out_valid;
    out_reg_d   = out_reg;
    out_data_d  = out_data;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_READ;
          idx_d     = FIRST_IDX;
          rd_addr_d = FIRST_IDX;
        end
      end
      S_READ: begin
        if (SKIP_ZERO && (rd_data == 32'd0)) begin
          // Advance is guarded by at_last so LAST_REG=31 never wraps to 0.
          if (at_last) begin
            state_d = S_DONE;
          end else begin
            idx_d     = idx_q + 5'd1;
            rd_addr_d = idx_q + 5'd1;
          end
        end else begin
          out_reg_d   = idx_q;
          out_data_d  = rd_data;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          if (at_last) begin
            state_d = S_DONE;
          end else begin
            idx_d     = idx_q + 5'd1;
            rd_addr_d = idx_q + 5'd1;
            state_d   = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        rd_addr_d = 5'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and beat registers; reset drops any beat in flight with no done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 5'd0;
      rd_addr   <= 5'd0;
      out_valid <= 1'b0;
      out_reg   <= 5'd0;
      out_data  <= 32'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rd_addr   <= rd_addr_d;
      out_valid <= out_valid_d;
      out_reg   <= out_reg_d;
      out_data  <= out_data_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign stall_req = busy;
  assign done      = (state_q == S_DONE);

endmodule
